inst_fetch_ctrl: RTL and testbench
==================================

// Module: inst_fetch_ctrl
// PURPOSE
//  Fetch sequencer between the PC/redirect logic and the word-wide instruction memory.
//  Issues word-aligned reads, buffers up to 3 halfwords and realigns mixed 16/32-bit
//  RV32IC instructions, including 32-bit instructions that straddle a word boundary.
//  Presents one instruction at a time to decode over a valid/ready handshake.
//  Branch/jump redirects flush the buffer. Memory data in flight at a redirect is discarded.
// PARAMETERS
//  ADDR_W    8   byte-address width; addresses wrap modulo 2^ADDR_W
//  RESET_PC  0   first PC after reset; halfword aligned
// PORTS
//  clk              in   1       clock; all state on rising edge
//  rst_n            in   1       asynchronous active-low reset
//  mem_req          out  1       read request to instruction memory
//  mem_addr         out  ADDR_W  word-aligned byte address; bits[1:0] always 0
//  mem_ack          in   1       read data valid; may assert in the same cycle as mem_req
//  mem_rdata        in   32      read word; sampled on clk edge with mem_req&mem_ack
//  redirect_valid   in   1       one-cycle pulse: restart fetch at redirect_pc
//  redirect_pc      in   ADDR_W  new PC; bit0 ignored
//  inst_valid       out  1       inst_out/inst_pc/inst_compressed valid
//  inst_ready       in   1       decode accepts the instruction when inst_valid&inst_ready
//  inst_out         out  32      instruction; compressed -> {16'h0,hw}
//  inst_pc          out  ADDR_W  byte PC of inst_out
//  inst_compressed  out  1       1 = 16-bit instruction; drives the memory step/PC+2 logic
// BEHAVIOUR
//  Reset: mem_req=0, mem_addr=RESET_PC&~3, inst_valid=0, inst_out=0, inst_pc=RESET_PC,
//   inst_compressed=0, buffer count=0, FSM=IDLE.
//   skip_low=RESET_PC[1]: discard the low halfword of the first returned word.
//  Buffer: hb[0..2] halfwords plus count 0..3. hb[0] sits at inst_pc.
//  Compressed test: hb[0][1:0] != 2'b11.
//  inst_valid (combinational from registers) is 1 when either
//   - count>=2, or
//   - count>=1 and hb[0] is compressed.
//   inst_valid is forced 0 in any cycle where redirect_valid=1.
//  Consume on valid&ready: shift out 1 halfword (compressed) or 2; inst_pc += 2 or 4.
//  FSM:
//   IDLE: move to WAIT and assert mem_req when count<=1 and no redirect this cycle.
//   WAIT: hold mem_req=1 and mem_addr stable until mem_ack.
//    On ack: append the word's halfwords to the buffer.
//     Append 2 halfwords, or only the upper 1 if skip_low; then clear skip_low.
//    Then: mem_addr += 4 (wraps); go to IDLE, or re-request back-to-back if count'<=1.
//   DROP: entered from WAIT when a redirect arrives before ack; mem_req stays 1.
//    On ack: discard data, go to IDLE. One outstanding read at a time; never drop mem_req early.
//  Same-cycle consume+fill: count' = count - consumed + appended. Never exceeds 3.
//  Straddle: a 32-bit instruction with its low half in hb[0] waits (inst_valid=0) until the
//   next word arrives. inst_out = {hb[1],hb[0]}.
//  Redirect (highest priority): count=0; inst_pc=redirect_pc&~1; mem_addr=redirect_pc&~3;
//   skip_low=redirect_pc[1].
//   Any handshake in that cycle is ignored.
//   A redirect arriving together with ack discards that data.
//   A redirect during DROP restarts at the newest PC.
//  Outputs hold stable while inst_valid=1 and inst_ready=0.
//  Reset asserted mid-operation: immediate return to reset values; pending ack ignored.
// CONFIGURATION
//  IFETCH_RVC_EN defined: compressed support as described above.
//  Undefined:
//   - every instruction is 32-bit and inst_compressed is tied 0;
//   - redirect_pc[1:0] and RESET_PC[1:0] are ignored and skip_low is never set;
//   - the buffer only ever holds whole words.
// TESTING
//  1 Reset with RESET_PC=0: all outputs at reset values. In the first cycle after
//    rst_n rises: mem_req=1, mem_addr=0.
//  2 Zero-latency memory, word0=0x00500093, word1=0x45014501:
//    expect 0x00500093@0 (c=0), then 0x00004501@4 (c=1), then 0x00004501@6 (c=1).
//  3 Straddle, word0=0x00934505, word1=0x00010050:
//    expect 0x00004505@0 (c=1), 0x00500093@2 (c=0), 0x00000001@6 (c=1).
//  4 Hold inst_ready=0 for 5 cycles with a full buffer:
//    inst_out/inst_pc stable; mem_req stays 0 while count>=2.
//  5 Memory ack latency 3; redirect_pc=0x06 while in WAIT:
//    - the old data is discarded;
//    - the next mem_addr is 0x04;
//    - the first inst_pc is 0x06, taken from the upper halfword.
//  6 IFETCH_RVC_EN undefined, word=0x00004501:
//    inst_out=0x00004501, inst_compressed=0, inst_pc advances by 4.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: word-wide memory reads, a 3-halfword realignment buffer, one
// instruction per valid/ready handshake. `define IFETCH_RVC_EN enables 16-bit (RVC) support.
module inst_fetch_ctrl #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_compressed
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    localparam logic [ADDR_W-1:0] START_ADDR = {RESET_PC[ADDR_W-1:2], 2'b00};

`ifdef IFETCH_RVC_EN
    localparam logic [ADDR_W-1:0] START_PC   = {RESET_PC[ADDR_W-1:1], 1'b0};
    localparam logic              START_SKIP = RESET_PC[1];
`else
    localparam logic [ADDR_W-1:0] START_PC   = START_ADDR;
    localparam logic              START_SKIP = 1'b0;
`endif

    state_t            state, state_n;
    logic [2:0][15:0]  hb, hb_n, shifted;
    logic [1:0]        count, count_n, consumed, remain;
    logic [ADDR_W-1:0] fetch_addr, drop_addr;
    logic              skip_low;
    logic              hb0_compressed;
    logic              fire, take;
    logic [ADDR_W-1:0] redir_pc, redir_addr;
    logic              redir_skip;
    logic              unused_pc_bits;

    assign redir_addr = {redirect_pc[ADDR_W-1:2], 2'b00};

`ifdef IFETCH_RVC_EN
    assign hb0_compressed = (hb[0][1:0] != 2'b11);
    assign redir_pc       = {redirect_pc[ADDR_W-1:1], 1'b0};
    assign redir_skip     = redirect_pc[1];
`else
    assign hb0_compressed = 1'b0;
    assign redir_pc       = redir_addr;
    assign redir_skip     = 1'b0;
`endif

    assign unused_pc_bits = &{1'b0, redirect_pc[1:0]};

    assign inst_compressed = (count != 2'd0) && hb0_compressed;
    assign inst_valid      = !redirect_valid &&
                             ((count >= 2'd2) || ((count == 2'd1) && hb0_compressed));
    assign inst_out        = inst_compressed ? {16'h0000, hb[0]} : {hb[1], hb[0]};

    // While dropping, the abandoned request's address stays on the bus until its ack.
    assign mem_req  = (state != S_IDLE);
    assign mem_addr = (state == S_DROP) ? drop_addr : fetch_addr;

    assign fire = inst_valid && inst_ready;
    assign take = (state == S_WAIT) && mem_ack && !redirect_valid;

    // Consume from the head first, then append the returned word behind what remains.
    always_comb begin
        consumed = 2'd0;
        if (fire) begin
            consumed = inst_compressed ? 2'd1 : 2'd2;
        end
        remain  = count - consumed;
        shifted = hb;
        if (consumed == 2'd1) begin
            shifted[0] = hb[1];
            shifted[1] = hb[2];
        end else if (consumed == 2'd2) begin
            shifted[0] = hb[2];
        end
        hb_n    = shifted;
        count_n = remain;
        if (take) begin
            for (int i = 0; i < 3; i++) begin
                if (skip_low) begin
                    if (i == int'(remain)) hb_n[i] = mem_rdata[31:16];
                end else begin
                    if (i == int'(remain))          hb_n[i] = mem_rdata[15:0];
                    else if (i == int'(remain) + 1) hb_n[i] = mem_rdata[31:16];
                end
            end
            count_n = remain + (skip_low ? 2'd1 : 2'd2);
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (!redirect_valid && (count <= 2'd1)) state_n = S_WAIT;
            S_WAIT: begin
                if (redirect_valid)   state_n = mem_ack ? S_IDLE : S_DROP;
                else if (mem_ack)     state_n = (count_n <= 2'd1) ? S_WAIT : S_IDLE;
            end
            S_DROP: if (mem_ack) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            hb         <= '0;
            count      <= 2'd0;
            inst_pc    <= START_PC;
            fetch_addr <= START_ADDR;
            drop_addr  <= START_ADDR;
            skip_low   <= START_SKIP;
        end else begin
            state <= state_n;
            if (redirect_valid) begin
                count      <= 2'd0;
                inst_pc    <= redir_pc;
                fetch_addr <= redir_addr;
                skip_low   <= redir_skip;
            end else begin
                hb    <= hb_n;
                count <= count_n;
                if (fire) begin
                    inst_pc <= inst_pc + (inst_compressed ? ADDR_W'(2) : ADDR_W'(4));
                end
                if (take) begin
                    fetch_addr <= fetch_addr + ADDR_W'(4);
                    skip_low   <= 1'b0;
                end
            end
            if ((state == S_WAIT) && redirect_valid && !mem_ack) begin
                drop_addr <= fetch_addr;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: directed memory images with hand-computed
// instruction streams; expectations follow the IFETCH_RVC_EN build setting.
module tb_inst_fetch_ctrl;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              inst_valid;
    logic              inst_ready = 1'b0;
    logic [31:0]       inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_compressed;

    typedef struct {
        logic [31:0]       data;
        logic [ADDR_W-1:0] pc;
        logic              c;
    } exp_t;

    exp_t              sb[$];
    logic [ADDR_W-1:0] addr_log[$];
    logic [31:0]       mem[64];
    int                latency = 0;
    int                lat_cnt;
    int                checks = 0;
    int                passed = 0;
    int                hs_count = 0;

    inst_fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
        .inst_pc(inst_pc), .inst_compressed(inst_compressed)
    );

    always #5 clk = ~clk;

    // Memory model: ack once the request has been pending for 'latency' cycles.
    assign mem_ack   = mem_req && (lat_cnt >= latency);
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt <= 0;
        end else if (mem_req && mem_ack) begin
            lat_cnt <= 0;
            addr_log.push_back(mem_addr);
        end else if (mem_req) begin
            lat_cnt <= lat_cnt + 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // Monitor: every accepted instruction is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready) begin
            if (sb.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_inst: got 0x%08h @0x%02h, expected none",
                         inst_out, inst_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("inst_out", inst_out, e.data);
                check_output("inst_pc", 32'(inst_pc), 32'(e.pc));
                check_output("inst_compressed", 32'(inst_compressed), 32'(e.c));
            end
            hs_count++;
        end
    end

    task automatic expect_inst(input logic [31:0] data, input logic [ADDR_W-1:0] pc,
                               input logic c);
        exp_t e;
        e.data = data;
        e.pc   = pc;
        e.c    = c;
        sb.push_back(e);
    endtask

    task automatic do_reset(input int lat, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2);
        rst_n          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        latency        = lat;
        sb.delete();
        addr_log.delete();
        hs_count = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = w0;
        mem[1] = w1;
        mem[2] = w2;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
    endtask

    // Accept instructions until 'target' handshakes have happened, then stall decode.
    task automatic apply_stimulus(input int target, input string name);
        bit done = 0;
        inst_ready = 1'b1;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(posedge clk);
            #1;
            if (hs_count >= target) done = 1;
        end
        inst_ready = 1'b0;
        if (!done) begin
            checks++;
            $display("[TB] FAIL %s_timeout: got %0d instructions, expected %0d",
                     name, hs_count, target);
        end
        check_output({name, "_sb_drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // Reset values and first request
        do_reset(0, 32'h00500093, 32'h45014501, 32'h00A00113);
        check_output("rst_mem_req", 32'(mem_req), 32'd0);
        check_output("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_output("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_output("rst_inst_out", inst_out, 32'd0);
        check_output("rst_inst_pc", 32'(inst_pc), 32'd0);
        check_output("rst_inst_compressed", 32'(inst_compressed), 32'd0);
        release_reset();
        @(posedge clk);
        #1;
        check_output("first_mem_req", 32'(mem_req), 32'd1);
        check_output("first_mem_addr", 32'(mem_addr), 32'd0);

        // Zero-latency stream with mixed sizes
`ifdef IFETCH_RVC_EN
        expect_inst(32'h00500093, 8'h00, 1'b0);
        expect_inst(32'h00004501, 8'h04, 1'b1);
        expect_inst(32'h00004501, 8'h06, 1'b1);
        apply_stimulus(3, "mixed");
`else
        expect_inst(32'h00500093, 8'h00, 1'b0);
        expect_inst(32'h45014501, 8'h04, 1'b0);
        apply_stimulus(2, "mixed");
`endif

        // Decode stalled with a full buffer: outputs frozen, no fetches
        repeat (6) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_output("stall_valid", 32'(inst_valid), 32'd1);
            check_output("stall_inst_out", inst_out, 32'h00A00113);
            check_output("stall_inst_pc", 32'(inst_pc), 32'h08);
            check_output("stall_mem_req", 32'(mem_req), 32'd0);
        end

        // Word-straddling 32-bit instruction
        do_reset(0, 32'h00934505, 32'h00010050, 32'h00000000);
        release_reset();
`ifdef IFETCH_RVC_EN
        expect_inst(32'h00004505, 8'h00, 1'b1);
        expect_inst(32'h00500093, 8'h02, 1'b0);
        expect_inst(32'h00000001, 8'h06, 1'b1);
        apply_stimulus(3, "straddle");
`else
        expect_inst(32'h00934505, 8'h00, 1'b0);
        expect_inst(32'h00010050, 8'h04, 1'b0);
        apply_stimulus(2, "straddle");
`endif

        // Redirect to 0x06 while a latency-3 read is outstanding
        do_reset(3, 32'hDEADBEEF, 32'h45051111, 32'h00500093);
        release_reset();
        @(posedge clk);
        #1;
        redirect_pc    = 8'h06;
        redirect_valid = 1'b1;
        check_output("redirect_masks_valid", 32'(inst_valid), 32'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check_output("drop_keeps_req", 32'(mem_req), 32'd1);
        check_output("drop_addr_stable", 32'(mem_addr), 32'd0);
`ifdef IFETCH_RVC_EN
        expect_inst(32'h00004505, 8'h06, 1'b1);
        expect_inst(32'h00500093, 8'h08, 1'b0);
`else
        expect_inst(32'h45051111, 8'h04, 1'b0);
        expect_inst(32'h00500093, 8'h08, 1'b0);
`endif
        apply_stimulus(2, "redirect");
        check_output("next_req_addr", (addr_log.size() > 1) ? 32'(addr_log[1]) : 32'hFF, 32'h04);

`ifndef IFETCH_RVC_EN
        // Without RVC a compressed-looking word is still a 32-bit instruction
        do_reset(1, 32'h00004501, 32'h00004501, 32'h00000000);
        release_reset();
        expect_inst(32'h00004501, 8'h00, 1'b0);
        expect_inst(32'h00004501, 8'h04, 1'b0);
        apply_stimulus(2, "no_rvc");
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
